// File: rtl/bpred_pkg.sv
// Shared types and constant helpers for the branch predictor / BTB.
// No logic of its own: imported by bpred_btb and bpred_sat_ctr.
// No flow control.
package bpred_pkg;

    typedef enum logic {BP_IDLE, BP_SWEEP} bp_state_t;

    localparam int unsigned BP_CNT_W_MAX = 4;
    // MSB-aligned weakly-taken pattern; a CNT_W-bit counter takes the top CNT_W bits
    localparam logic [BP_CNT_W_MAX-1:0] BP_WEAK_INIT = 4'b1000;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v != 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bpred_sat_ctr.sv
// Saturating up/down next-value logic, shared by the table counters and the stats.
// Combinational, zero latency.
// No flow control; inc and dec together hold the value.
module bpred_sat_ctr
    import bpred_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (inc && !dec && (cur != {W{1'b1}})) begin
            nxt = cur + W'(1);
        end else if (dec && !inc && (cur != '0)) begin
            nxt = cur - W'(1);
        end
    end

endmodule

// File: rtl/bpred_btb.sv
// Direct-mapped branch predictor + BTB; optional saturating stats under BPRED_STATS_EN.
// Lookup is combinational; updates land at the next edge with no bypass.
// No backpressure: updates arriving while busy or on a clear cycle are dropped.
module bpred_btb
    import bpred_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lk_pc,
    output logic              lk_taken,
    output logic [ADDR_W-1:0] lk_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_mispredict,
    input  logic              clear,
    output logic              busy,
    output logic [STAT_W-1:0] stat_updates,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned IDX_W = clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - IDX_W;
    localparam logic [CNT_W-1:0] WEAK_INIT = BP_WEAK_INIT[BP_CNT_W_MAX-1 -: CNT_W];

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [CNT_W-1:0]  ctr;
        logic [ADDR_W-1:0] target;
    } entry_t;

    entry_t tbl [ENTRIES];

    bp_state_t        state, state_d;
    logic [IDX_W-1:0] ptr, ptr_d;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    entry_t           wr_dat;

    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit;
    logic [IDX_W-1:0] upd_idx;
    entry_t           upd_ent;
    logic             upd_hit;
    logic             upd_acc;
    logic [CNT_W-1:0] ctr_nxt;

    assign busy = (state == BP_SWEEP);

    assign lk_idx    = lk_pc[IDX_W-1:0];
    assign lk_hit    = tbl[lk_idx].valid && (tbl[lk_idx].tag == lk_pc[ADDR_W-1:IDX_W]);
    assign lk_taken  = lk_hit && tbl[lk_idx].ctr[CNT_W-1] && !busy;
    assign lk_target = lk_taken ? tbl[lk_idx].target : '0;

    assign upd_idx = upd_pc[IDX_W-1:0];
    assign upd_ent = tbl[upd_idx];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_pc[ADDR_W-1:IDX_W]);
    assign upd_acc = upd_valid && !busy && !clear && !rst;

    bpred_sat_ctr #(.W(CNT_W)) u_ctr (
        .cur (upd_ent.ctr),
        .inc (upd_taken),
        .dec (!upd_taken),
        .nxt (ctr_nxt)
    );

    // Single table write port: the sweep owns it while busy, updates otherwise
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        wr_en   = 1'b0;
        wr_idx  = upd_idx;
        wr_dat  = '0;
        if (rst || clear) begin
            state_d = BP_SWEEP;
            ptr_d   = '0;
        end else if (state == BP_SWEEP) begin
            ptr_d = ptr + IDX_W'(1);
            if (ptr == IDX_W'(ENTRIES - 1)) begin
                state_d = BP_IDLE;
            end
        end
        if (state == BP_SWEEP) begin
            wr_en  = 1'b1;
            wr_idx = ptr;
        end else if (upd_acc && (upd_hit || upd_taken)) begin
            wr_en         = 1'b1;
            wr_dat.valid  = 1'b1;
            wr_dat.tag    = upd_pc[ADDR_W-1:IDX_W];
            wr_dat.ctr    = upd_hit ? ctr_nxt : WEAK_INIT;
            wr_dat.target = upd_taken ? upd_target : upd_ent.target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BP_SWEEP;
            ptr   <= '0;
        end else begin
            state <= state_d;
            ptr   <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tbl[wr_idx] <= wr_dat;
        end
    end

`ifdef BPRED_STATS_EN
    logic [STAT_W-1:0] upd_cnt, upd_cnt_nxt;
    logic [STAT_W-1:0] mis_cnt, mis_cnt_nxt;

    bpred_sat_ctr #(.W(STAT_W)) u_upd_cnt (
        .cur (upd_cnt),
        .inc (upd_acc),
        .dec (1'b0),
        .nxt (upd_cnt_nxt)
    );

    bpred_sat_ctr #(.W(STAT_W)) u_mis_cnt (
        .cur (mis_cnt),
        .inc (upd_acc && upd_mispredict),
        .dec (1'b0),
        .nxt (mis_cnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            upd_cnt <= '0;
            mis_cnt <= '0;
        end else begin
            upd_cnt <= upd_cnt_nxt;
            mis_cnt <= mis_cnt_nxt;
        end
    end

    assign stat_updates     = upd_cnt;
    assign stat_mispredicts = mis_cnt;
`else
    logic unused_stats;
    assign unused_stats     = upd_mispredict;
    assign stat_updates     = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_bpred_btb.sv
// Directed scoreboard bench for bpred_btb (ENTRIES=16, CNT_W=2), plus a STAT_W=2 copy
// sharing the same stimulus to exercise stat saturation.
module tb_bpred_btb;

`ifdef BPRED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] lk_pc;
    logic        lk_taken, lk_taken2;
    logic [15:0] lk_target, lk_target2;
    logic        upd_valid;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic        upd_mispredict;
    logic        clear;
    logic        busy, busy2;
    logic [15:0] stat_updates, stat_mispredicts;
    logic [1:0]  stat_updates2, stat_mispredicts2;

    int n_cmp = 0;
    int n_err = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    bpred_btb dut (
        .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_taken(lk_taken), .lk_target(lk_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .clear(clear), .busy(busy),
        .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
    );

    bpred_btb #(.STAT_W(2)) dut2 (
        .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_taken(lk_taken2), .lk_target(lk_target2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_mispredict(upd_mispredict), .clear(clear), .busy(busy2),
        .stat_updates(stat_updates2), .stat_mispredicts(stat_mispredicts2)
    );

    function automatic logic [31:0] sx(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    function automatic logic [31:0] sx2(input int v);
        return STATS ? ((v > 3) ? 32'd3 : 32'(v)) : 32'd0;
    endfunction

    task automatic push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL sb_empty: observed 0x%0h required an expectation", obs);
            return;
        end
        tag = tag_q.pop_front();
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [15:0] pc, input logic tk, input logic [15:0] tgt);
        push({tag, "_taken"}, 32'(tk));
        push({tag, "_target"}, 32'(tgt));
        lk_pc = pc;
        #1;
        pop_check(32'(lk_taken));
        pop_check(32'(lk_target));
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_check(obs);
    endtask

    task automatic upd(input logic v, input logic [15:0] pc, input logic tk,
                       input logic [15:0] tgt, input logic mp);
        upd_valid      = v;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = mp;
    endtask

    task automatic check_stats(input string tag, input int n_upd, input int n_mis);
        chk({tag, "_stat_updates"}, 32'(stat_updates), sx(n_upd));
        chk({tag, "_stat_mispredicts"}, 32'(stat_mispredicts), sx(n_mis));
        chk({tag, "_stat_updates_w2"}, 32'(stat_updates2), sx2(n_upd));
        chk({tag, "_stat_mispredicts_w2"}, 32'(stat_mispredicts2), sx2(n_mis));
    endtask

    task automatic busy_run(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, 32'(busy), 32'd1);
            look(tag, 16'($urandom), 1'b0, 16'h0000);
            @(negedge clk);
        end
    endtask

    logic        nt_pre [4]  = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        seq_tk [6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        seq_pre [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        lk_pc = 16'h0000;
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset sweep: 16 busy cycles; an update late in the sweep must be dropped
        check_stats("reset", 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 12) upd(1'b1, 16'h0005, 1'b1, 16'h0055, 1'b1);
            else         upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
            chk("reset_busy", 32'(busy), 32'd1);
            look("reset_lk", 16'($urandom), 1'b0, 16'h0000);
            @(negedge clk);
        end
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        chk("reset_done_busy", 32'(busy), 32'd0);
        chk("reset_done_busy_w2", 32'(busy2), 32'd0);
        look("drop_busy", 16'h0005, 1'b0, 16'h0000);
        check_stats("drop_busy", 0, 0);

        // Allocate on miss+taken; same-cycle lookup still sees the empty entry
        upd(1'b1, 16'h0013, 1'b1, 16'h0040, 1'b0);
        look("alloc_same_cycle", 16'h0013, 1'b0, 16'h0000);
        @(negedge clk);
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        look("alloc_hit", 16'h0013, 1'b1, 16'h0040);
        chk("alloc_hit_w2", 32'(lk_target2), 32'h0040);
        look("alloc_other_tag", 16'h0023, 1'b0, 16'h0000);

        // Four not-taken: 2->1->0->0; the lookup each cycle sees the pre-update value
        for (int k = 0; k < 4; k++) begin
            upd(1'b1, 16'h0013, 1'b0, 16'h0000, (k < 2) ? 1'b1 : 1'b0);
            look("nt_pre", 16'h0013, nt_pre[k], nt_pre[k] ? 16'h0040 : 16'h0000);
            @(negedge clk);
        end
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        look("nt_after", 16'h0013, 1'b0, 16'h0000);
        check_stats("five_upd", 5, 2);

        // T,T,T,T,N,N from ctr=0: climbs, saturates at 3, then decays to 1
        for (int k = 0; k < 6; k++) begin
            upd(1'b1, 16'h0013, seq_tk[k], 16'h0077, 1'b0);
            look("sat_pre", 16'h0013, seq_pre[k], seq_pre[k] ? 16'h0077 : 16'h0000);
            @(negedge clk);
        end
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        look("sat_after", 16'h0013, 1'b0, 16'h0000);

        // Conflicting allocation replaces; miss+not-taken leaves the table alone
        upd(1'b1, 16'h0023, 1'b1, 16'h0099, 1'b0);
        look("replace_pre", 16'h0023, 1'b0, 16'h0000);
        @(negedge clk);
        upd(1'b1, 16'h0033, 1'b0, 16'h0011, 1'b0);
        look("replace_hit", 16'h0023, 1'b1, 16'h0099);
        look("replace_old", 16'h0013, 1'b0, 16'h0000);
        @(negedge clk);
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        look("nt_miss_nochg", 16'h0023, 1'b1, 16'h0099);
        look("nt_miss_noalloc", 16'h0033, 1'b0, 16'h0000);
        check_stats("pre_clear", 13, 2);

        // clear with a concurrent update: update dropped, stats zeroed, sweep restarts mid-way
        clear = 1'b1;
        upd(1'b1, 16'h0005, 1'b1, 16'h0055, 1'b1);
        look("clear_cycle", 16'h0023, 1'b1, 16'h0099);
        @(negedge clk);
        clear = 1'b0;
        upd(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check_stats("clear", 0, 0);
        busy_run("clear_busy", 7);
        clear = 1'b1;
        chk("restart_busy", 32'(busy), 32'd1);
        @(negedge clk);
        clear = 1'b0;
        busy_run("restart_busy", 16);
        chk("restart_done_busy", 32'(busy), 32'd0);
        look("clear_miss_a", 16'h0023, 1'b0, 16'h0000);
        look("clear_miss_b", 16'h0005, 1'b0, 16'h0000);
        check_stats("post_clear", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
